multi_bbox_tracker: RTL
=======================

Name: multi_bbox_tracker

Overview:
- Parametrised successor to the single-blob bounding-box centroid block. It tracks NUM_CH independent colour/mask channels in one raster pass. Each channel keeps its own x/y extents and pixel count.
- On end-of-frame (tabulate_in) all channels are snapshotted together. Each channel's centre, elliptical mass estimate and a found flag are then streamed out one channel at a time over a valid/ready handshake.
- Sits between the per-pixel mask/threshold stage and the sundial shadow/gnomon tracking logic.

Parameters:
- H_WIDTH, 11, horizontal coordinate width.
- V_WIDTH, 10, vertical coordinate width.
- NUM_CH, 4, number of tracked channels (>=1).
- MASS_WIDTH, 32, width of mass_out.
- MIN_PIXELS, 16, minimum pixel count for a channel to be reported as found.
- PI_NUM, 201, numerator of the pi estimate.
- PI_SHIFT, 6, right shift applied after multiplying by PI_NUM.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  synchronous reset, active-low.
- x_in  input  H_WIDTH  pixel x coordinate.
- y_in  input  V_WIDTH  pixel y coordinate.
- ch_in  input  CH_W=max(1,$clog2(NUM_CH))  channel the pixel belongs to.
- valid_in  input  1  pixel qualifier.
- tabulate_in  input  1  end-of-frame strobe (single cycle).
- ready_in  input  1  downstream ready.
- valid_out  output  1  result valid.
- ch_out  output  CH_W  channel index of the current result.
- x_out  output  H_WIDTH  centre x.
- y_out  output  V_WIDTH  centre y.
- mass_out  output  MASS_WIDTH  area estimate.
- count_out  output  H_WIDTH+V_WIDTH  pixel count.
- found_out  output  1  count_out >= MIN_PIXELS.
- frame_done_out  output  1  one-cycle pulse after the last channel's handshake.
- overrun_out  output  1  one-cycle pulse when tabulate_in arrives while results are still being emitted.

Behaviour:
- Reset (rst_n_in=0 at a clock edge): all outputs 0. Accumulators go to min=all-ones, max=0, count=0. FSM goes to IDLE. Any in-flight emission is aborted with no frame_done_out.
- Accumulate:
  - Every cycle with valid_in=1 and ch_in<NUM_CH, update that channel's x_min/x_max/y_min/y_max and increment its count.
  - Count saturates at all-ones.
  - Pixels with ch_in>=NUM_CH are ignored.
  - Accumulation continues in every FSM state.
- Tabulate, in IDLE:
  - A pixel present in the same cycle as tabulate_in is included in the closing frame.
  - All channel accumulators are copied to snapshot registers and cleared in that same edge.
  - FSM goes to CALC with ch index 0.
- Tabulate while not IDLE: the accumulators are cleared (frame discarded), the snapshot is untouched, overrun_out pulses for 1 cycle, and emission continues.
- FSM states are IDLE, CALC and EMIT.
  - CALC (1 cycle): register the outputs for the current ch index, go to EMIT, and assert valid_out.
  - EMIT: hold every output stable while valid_out=1 and ready_in=0.
  - On valid_out & ready_in: deassert valid_out. If ch==NUM_CH-1, pulse frame_done_out and go to IDLE. Otherwise increment ch and go to CALC.
- Latency: tabulate sampled at edge T gives valid_out high after edge T+1 for ch0. Throughput is at most one result per 2 cycles.
- Arithmetic:
  - x_out=(x_max+x_min)>>1 and y_out=(y_max+y_min)>>1, computed with a 1-bit-wider sum (no overflow).
  - dx=x_max-x_min and dy=y_max-y_min.
  - mass_out=(dx*dy*PI_NUM)>>PI_SHIFT, computed at full product width and saturated to MASS_WIDTH.
- Empty channel (count==0):
  - x_out=y_out=mass_out=0 and found_out=0.
  - The channel is still emitted, so the stream always carries NUM_CH results per frame.
- Single-pixel channel: dx=dy=0, mass_out=0, centre equals that pixel. found_out is set per MIN_PIXELS.

Decomposition:
- Package bbox_pkg holds:
  - The FSM state enum (IDLE, CALC, EMIT).
  - The default PI_NUM/PI_SHIFT constants.
  - A packed struct bbox_acc_t {x_min, x_max, y_min, y_max, count}.
- Sub-module bbox_accumulator holds one channel's extents and count. It has a clear input (shared with tabulate) and a hit input (valid_in & ch_in==i), and is instantiated NUM_CH times via generate.
- The top level contains the snapshot registers, the FSM and the output datapath.

Test Plan:
- Single channel: ch0 pixels fill x 100..140 and y 50..70, then tabulate. Expect ch0 x_out=120, y_out=60, count=861, mass_out=(40*20*201)>>6=2512 and found=1. ch1..3 show count=0 with found=0. frame_done_out pulses after ch3.
- Backpressure: ready_in held low for 5 cycles on ch1. Outputs must stay stable and valid_out must stay high. Releasing ready_in advances to ch2 exactly 2 cycles later.
- Tabulate coincident with pixel (ch2, x=10, y=10), with ch2 otherwise empty. The pixel appears in this frame's ch2 result (centre 10,10, count 1), and the next frame's ch2 is empty.
- Overrun: a second tabulate arrives during ch1's EMIT. Expect overrun_out to pulse, the current ch1..3 results to be unchanged, and the accumulators to be cleared.
- MIN_PIXELS boundary: 15 pixels gives found=0 and 16 pixels gives found=1. ch_in=NUM_CH (with NUM_CH=3) is ignored.
- Reset mid-EMIT: all outputs go to 0, no frame_done_out occurs, and the next frame reports only post-reset pixels.

Source files
------------

// File: rtl/bbox_pkg.sv
// Shared types and default constants for the multi-channel bounding-box tracker.
package bbox_pkg;

  localparam int unsigned BBOX_H_WIDTH   = 11;
  localparam int unsigned BBOX_V_WIDTH   = 10;
  localparam int unsigned BBOX_CNT_WIDTH = BBOX_H_WIDTH + BBOX_V_WIDTH;
  localparam int unsigned BBOX_PI_NUM    = 201;
  localparam int unsigned BBOX_PI_SHIFT  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_EMIT = 2'd2
  } bbox_state_e;

  // Per-channel accumulator contents at the default coordinate widths.
  typedef struct packed {
    logic [BBOX_H_WIDTH-1:0]   x_min;
    logic [BBOX_H_WIDTH-1:0]   x_max;
    logic [BBOX_V_WIDTH-1:0]   y_min;
    logic [BBOX_V_WIDTH-1:0]   y_max;
    logic [BBOX_CNT_WIDTH-1:0] count;
  } bbox_acc_t;

endpackage

// File: rtl/bbox_accumulator.sv
// One channel's running x/y extents and saturating pixel count.
// The *_c outputs include a pixel hitting this cycle so a coincident clear can snapshot it.
module bbox_accumulator #(
  parameter int unsigned H_WIDTH = 11,
  parameter int unsigned V_WIDTH = 10
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       clear_in,
  input  logic                       hit_in,
  input  logic [H_WIDTH-1:0]         x_in,
  input  logic [V_WIDTH-1:0]         y_in,
  output logic [H_WIDTH-1:0]         x_min_c,
  output logic [H_WIDTH-1:0]         x_max_c,
  output logic [V_WIDTH-1:0]         y_min_c,
  output logic [V_WIDTH-1:0]         y_max_c,
  output logic [H_WIDTH+V_WIDTH-1:0] count_c
);

  localparam int unsigned CNT_W = H_WIDTH + V_WIDTH;

  logic [H_WIDTH-1:0] r_x_min;
  logic [H_WIDTH-1:0] r_x_max;
  logic [V_WIDTH-1:0] r_y_min;
  logic [V_WIDTH-1:0] r_y_max;
  logic [CNT_W-1:0]   r_count;

  always_comb begin
    x_min_c = r_x_min;
    x_max_c = r_x_max;
    y_min_c = r_y_min;
    y_max_c = r_y_max;
    count_c = r_count;
    if (hit_in) begin
      if (x_in < r_x_min) x_min_c = x_in;
      if (x_in > r_x_max) x_max_c = x_in;
      if (y_in < r_y_min) y_min_c = y_in;
      if (y_in > r_y_max) y_max_c = y_in;
      if (r_count != {CNT_W{1'b1}}) count_c = r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in || clear_in) begin
      r_x_min <= '1;
      r_x_max <= '0;
      r_y_min <= '1;
      r_y_max <= '0;
      r_count <= '0;
    end else begin
      r_x_min <= x_min_c;
      r_x_max <= x_max_c;
      r_y_min <= y_min_c;
      r_y_max <= y_max_c;
      r_count <= count_c;
    end
  end

endmodule

// File: rtl/multi_bbox_tracker.sv
// Tracks NUM_CH mask channels per frame; on tabulate snapshots all channels and
// streams centre, elliptical mass and found flag per channel over valid/ready.
module multi_bbox_tracker
  import bbox_pkg::*;
#(
  parameter int unsigned H_WIDTH    = 11,
  parameter int unsigned V_WIDTH    = 10,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned MASS_WIDTH = 32,
  parameter int unsigned MIN_PIXELS = 16,
  parameter int unsigned PI_NUM     = BBOX_PI_NUM,
  parameter int unsigned PI_SHIFT   = BBOX_PI_SHIFT,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [H_WIDTH-1:0]         x_in,
  input  logic [V_WIDTH-1:0]         y_in,
  input  logic [CH_W-1:0]            ch_in,
  input  logic                       valid_in,
  input  logic                       tabulate_in,
  input  logic                       ready_in,
  output logic                       valid_out,
  output logic [CH_W-1:0]            ch_out,
  output logic [H_WIDTH-1:0]         x_out,
  output logic [V_WIDTH-1:0]         y_out,
  output logic [MASS_WIDTH-1:0]      mass_out,
  output logic [H_WIDTH+V_WIDTH-1:0] count_out,
  output logic                       found_out,
  output logic                       frame_done_out,
  output logic                       overrun_out
);

  localparam int unsigned CNT_W   = H_WIDTH + V_WIDTH;
  localparam int unsigned PI_W    = $clog2(PI_NUM + 1);
  localparam int unsigned PROD_W  = H_WIDTH + V_WIDTH + PI_W;
  localparam int unsigned P_W     = (PROD_W > MASS_WIDTH) ? PROD_W : MASS_WIDTH;

  logic [NUM_CH-1:0]  w_hit;
  logic [H_WIDTH-1:0] w_x_min [NUM_CH];
  logic [H_WIDTH-1:0] w_x_max [NUM_CH];
  logic [V_WIDTH-1:0] w_y_min [NUM_CH];
  logic [V_WIDTH-1:0] w_y_max [NUM_CH];
  logic [CNT_W-1:0]   w_count [NUM_CH];

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_acc
      assign w_hit[g] = valid_in && (32'(ch_in) == g);
      bbox_accumulator #(.H_WIDTH(H_WIDTH), .V_WIDTH(V_WIDTH)) u_acc (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clear_in (tabulate_in),
        .hit_in   (w_hit[g]),
        .x_in     (x_in),
        .y_in     (y_in),
        .x_min_c  (w_x_min[g]),
        .x_max_c  (w_x_max[g]),
        .y_min_c  (w_y_min[g]),
        .y_max_c  (w_y_max[g]),
        .count_c  (w_count[g])
      );
    end
  endgenerate

  bbox_state_e        r_state, w_state_nxt;
  logic [CH_W-1:0]    r_ch, w_ch_nxt;
  logic [H_WIDTH-1:0] r_s_x_min [NUM_CH];
  logic [H_WIDTH-1:0] r_s_x_max [NUM_CH];
  logic [V_WIDTH-1:0] r_s_y_min [NUM_CH];
  logic [V_WIDTH-1:0] r_s_y_max [NUM_CH];
  logic [CNT_W-1:0]   r_s_count [NUM_CH];

  // Snapshot only when idle; an overrun tabulate just discards the accumulators.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_s_x_min[i] <= '1;
        r_s_x_max[i] <= '0;
        r_s_y_min[i] <= '1;
        r_s_y_max[i] <= '0;
        r_s_count[i] <= '0;
      end
    end else if (tabulate_in && (r_state == ST_IDLE)) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_s_x_min[i] <= w_x_min[i];
        r_s_x_max[i] <= w_x_max[i];
        r_s_y_min[i] <= w_y_min[i];
        r_s_y_max[i] <= w_y_max[i];
        r_s_count[i] <= w_count[i];
      end
    end
  end

  logic r_valid, r_found, r_fd, r_ovr;
  logic w_valid_nxt, w_fd_nxt, w_ovr_nxt, w_load, w_last;

  assign w_last = (32'(r_ch) == NUM_CH - 1);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_valid_nxt = r_valid;
    w_fd_nxt    = 1'b0;
    w_load      = 1'b0;
    w_ovr_nxt   = tabulate_in && (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (tabulate_in) begin
          w_state_nxt = ST_CALC;
          w_ch_nxt    = '0;
        end
      end
      ST_CALC: begin
        w_load      = 1'b1;
        w_valid_nxt = 1'b1;
        w_state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        if (r_valid && ready_in) begin
          w_valid_nxt = 1'b0;
          if (w_last) begin
            w_fd_nxt    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_ch_nxt    = r_ch + CH_W'(1);
            w_state_nxt = ST_CALC;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result datapath for the channel currently selected by r_ch.
  logic [H_WIDTH-1:0]    w_sx_min, w_sx_max, w_dx, w_x_c;
  logic [V_WIDTH-1:0]    w_sy_min, w_sy_max, w_dy, w_y_c;
  logic [CNT_W-1:0]      w_scount;
  logic [H_WIDTH:0]      w_x_sum;
  logic [V_WIDTH:0]      w_y_sum;
  logic [P_W-1:0]        w_prod, w_scaled;
  logic [MASS_WIDTH-1:0] w_mass_c;
  logic                  w_empty;

  always_comb begin
    w_sx_min = r_s_x_min[r_ch];
    w_sx_max = r_s_x_max[r_ch];
    w_sy_min = r_s_y_min[r_ch];
    w_sy_max = r_s_y_max[r_ch];
    w_scount = r_s_count[r_ch];
    w_empty  = (w_scount == '0);
    w_x_sum  = (H_WIDTH+1)'(w_sx_min) + (H_WIDTH+1)'(w_sx_max);
    w_y_sum  = (V_WIDTH+1)'(w_sy_min) + (V_WIDTH+1)'(w_sy_max);
    w_x_c    = w_x_sum[H_WIDTH:1];
    w_y_c    = w_y_sum[V_WIDTH:1];
    w_dx     = w_sx_max - w_sx_min;
    w_dy     = w_sy_max - w_sy_min;
    w_prod   = P_W'(w_dx) * P_W'(w_dy) * P_W'(PI_NUM);
    w_scaled = w_prod >> PI_SHIFT;
    w_mass_c = (w_scaled > P_W'({MASS_WIDTH{1'b1}})) ? {MASS_WIDTH{1'b1}}
                                                      : MASS_WIDTH'(w_scaled);
  end

  logic [CH_W-1:0]       r_ch_out;
  logic [H_WIDTH-1:0]    r_x;
  logic [V_WIDTH-1:0]    r_y;
  logic [MASS_WIDTH-1:0] r_mass;
  logic [CNT_W-1:0]      r_count;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_valid  <= 1'b0;
      r_fd     <= 1'b0;
      r_ovr    <= 1'b0;
      r_ch_out <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_mass   <= '0;
      r_count  <= '0;
      r_found  <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      r_fd    <= w_fd_nxt;
      r_ovr   <= w_ovr_nxt;
      if (w_load) begin
        r_ch_out <= r_ch;
        r_count  <= w_scount;
        r_found  <= (w_scount >= CNT_W'(MIN_PIXELS));
        r_x      <= w_empty ? '0 : w_x_c;
        r_y      <= w_empty ? '0 : w_y_c;
        r_mass   <= w_empty ? '0 : w_mass_c;
      end
    end
  end

  assign valid_out      = r_valid;
  assign ch_out         = r_ch_out;
  assign x_out          = r_x;
  assign y_out          = r_y;
  assign mass_out       = r_mass;
  assign count_out      = r_count;
  assign found_out      = r_found;
  assign frame_done_out = r_fd;
  assign overrun_out    = r_ovr;

endmodule
